// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver.
// State encoding and default frame geometry.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_SYNC_W = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b1101;

endpackage

// File: rtl/serial_sync_detect.sv
// Sliding-window sync pattern detector.
// match is combinational on the bit being sampled this edge.
module serial_sync_detect
  import serial_frame_pkg::*;
#(
  parameter int unsigned SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic serial_in,
  input  logic restart,
  output logic match
);

  localparam int unsigned FW = $clog2(SYNC_W + 1);
  localparam logic [FW-1:0] FULL = FW'(SYNC_W);

  logic [SYNC_W-2:0] win;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fill_nxt;
  logic [SYNC_W-1:0] cand;

  // window including the incoming bit, saturating fill count
  always_comb begin
    cand     = {win, serial_in};
    fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
    match    = en && (fill_nxt == FULL) && (cand == SYNC_PAT);
  end

  // shift history on strobes, flush on reset or frame end
  always_ff @(posedge clk) begin
    if (clear || restart) begin
      win  <= '0;
      fill <= '0;
    end else if (en) begin
      win  <= cand[SYNC_W-2:0];
      fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, MSB-first word, even parity.
// Optional SERIAL_FRAME_RX_FRAME_CNT_EN adds a good-frame counter.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              serial_in,
  input  logic              en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
`ifdef SERIAL_FRAME_RX_FRAME_CNT_EN
  output logic [7:0]        frame_cnt,
`endif
  output logic              busy
);

  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              match;
  logic              hunt_en;
  logic              restart;
  logic              perr_nxt;

  // detector only sees strobes while hunting
  always_comb begin
    hunt_en  = en && (state == HUNT);
    restart  = en && (state == PARITY);
    perr_nxt = (^shreg) ^ serial_in;
  end

  serial_sync_detect #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync (
    .clk       (clk),
    .clear     (clear),
    .en        (hunt_en),
    .serial_in (serial_in),
    .restart   (restart),
    .match     (match)
  );

  // frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= HUNT;
      shreg      <= '0;
      bitcnt     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (en) begin
        unique case (state)
          HUNT: begin
            if (match) begin
              state  <= DATA;
              bitcnt <= '0;
              busy   <= 1'b1;
            end
          end
          DATA: begin
            shreg  <= {shreg[DATA_W-2:0], serial_in};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST) state <= PARITY;
          end
          PARITY: begin
            data_out   <= shreg;
            parity_err <= perr_nxt;
            data_valid <= 1'b1;
            state      <= HUNT;
            busy       <= 1'b0;
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SERIAL_FRAME_RX_FRAME_CNT_EN
  // counts frames that pass parity, updated with data_valid
  always_ff @(posedge clk) begin
    if (clear) begin
      frame_cnt <= '0;
    end else if (en && state == PARITY && !perr_nxt) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the single-bit registered serial stream produced by the selectable-input flip-flop stage (its q output).
- Hunts the stream for a fixed sync pattern, then shifts in a DATA_W-bit word (MSB first) followed by one even-parity bit.
- Presents the word in parallel with a one-cycle valid pulse and a parity-error flag.

Parameters:
- DATA_W, 8, payload width in bits (≥2).
- SYNC_W, 4, sync pattern width in bits (≥2).
- SYNC_PAT, 4'b1101, sync pattern, first-received bit in the MSB.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous, active-high reset.
- serial_in  input  1  serial bit stream (driven by the upstream q).
- en  input  1  bit strobe; serial_in is sampled only on edges where en=1.
- data_out  output  DATA_W  last received word, registered.
- data_valid  output  1  one-cycle pulse when data_out and parity_err update.
- parity_err  output  1  1 = last frame failed even parity; held until the next frame completes.
- busy  output  1  1 while in DATA or PARITY.

Behaviour:
- Reset (clear=1 at a rising edge; clear has priority over all other inputs):
  - state=HUNT; sync window and fill counter cleared.
  - data_out=0, data_valid=0, parity_err=0, busy=0.
- en=0: no state, window, counter or shift change; data_valid forced 0.
- HUNT:
  - On each en=1 edge, the window shifts left with serial_in entering the LSB; the fill counter increments, saturating at SYNC_W.
  - Match requires fill counter = SYNC_W (counting the bit just taken) and window (including that bit) = SYNC_PAT; on match go to DATA at that edge with bit counter=0.
  - Sliding window, so an overlapping prefix is detected at its first occurrence (e.g. 11101 matches on the 5th bit).
- DATA: each en=1 edge shifts serial_in into the shift register LSB and increments the bit counter; after the DATA_W-th bit go to PARITY.
- PARITY, on the en=1 edge:
  - data_out ← shift register; parity_err ← XOR(word, serial_in) (even parity expected, so 1 means error); data_valid=1 for exactly that following cycle.
  - state → HUNT with window and fill counter cleared, so frame bits never contribute to the next sync match.
- Latency: data_valid rises the clock edge that samples the parity bit, i.e. SYNC_W+DATA_W+1 sampled bits after the first sync bit.
- busy=1 in DATA and PARITY, 0 in HUNT; registered with state.
- Reset mid-frame: frame discarded, no data_valid, returns to HUNT as above.
- data_out and parity_err hold between frames; never X after reset.

Optional Feature:
- Macro: SERIAL_FRAME_RX_FRAME_CNT_EN.
- Defined: extra output frame_cnt [7:0]:
  - Cleared by clear.
  - Increments on each data_valid with parity_err=0; wraps 255→0.
  - Frames with a parity error are not counted.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package serial_frame_pkg holds:
  - State encoding constants HUNT=2'd0, DATA=2'd1, PARITY=2'd2.
  - Default DATA_W, SYNC_W and SYNC_PAT values, shared with the upstream stage's bench.
- One natural sub-module, serial_sync_detect: sync window, fill counter and match compare, with clk, clear, en, serial_in, restart and match ports.
- The main module keeps the FSM, data shift register, bit counter and outputs.

Test Plan:
- clear=1 for 2 cycles, then 0 → data_out=0x00, data_valid=0, parity_err=0, busy=0.
- en=1 every cycle; bits 1101, then 10100101 (0xA5), then parity 0 → one-cycle data_valid on the edge sampling the parity bit; data_out=0xA5; parity_err=0; busy=1 for 9 cycles; frame_cnt=1 when enabled.
- Same frame with parity bit 1 → data_out=0xA5, parity_err=1, frame_cnt unchanged.
- Same frame as scenario 2, but en alternates 1/0 and serial_in toggles randomly on en=0 cycles → identical result (0xA5, parity_err=0) after twice the cycles; data_valid high exactly one cycle.
- Bits 11101, then 0x3C (00111100), then parity 0 → sync detected on the 5th bit; data_out=0x3C, parity_err=0.
- Valid sync and 3 data bits, then clear=1 for one edge, then a full 0x5A frame with parity 0 → no data_valid for the aborted frame; data_out=0x5A, parity_err=0.
